// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU sequencer.
//   op_e     - operation codes carried on req_op (10..15 are illegal)
//   state_e  - sequencer FSM states
//   FLAGS_*  - flag write masks, bit order {N,Z,C,V}
//   BCD_*    - decimal correction terms added on the ADC adjust pass
//   bcd_k()  - builds the pass-2 correction addend from pass-1 results
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_ADC = 4'd0,
      OP_SBC = 4'd1,
      OP_AND = 4'd2,
      OP_ORA = 4'd3,
      OP_EOR = 4'd4,
      OP_LSR = 4'd5,
      OP_ROR = 4'd6,
      OP_ASL = 4'd7,
      OP_ROL = 4'd8,
      OP_CMP = 4'd9
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      ADJ  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [3:0] FLAGS_NZCV = 4'b1111;
   localparam logic [3:0] FLAGS_NZC  = 4'b1110;
   localparam logic [3:0] FLAGS_NZ   = 4'b1100;
   localparam logic [3:0] FLAGS_NONE = 4'b0000;

   localparam logic [7:0] BCD_LO_ADJ  = 8'h06;
   localparam logic [7:0] BCD_HI_ADJ  = 8'h60;
   localparam logic [7:0] BCD_NIB_FIX = 8'hF0;

   // Adding 6 to a low nibble of A..F carries into the high nibble, but
   // that carry was already folded in on pass 1; 0xF0 subtracts it back.
   function automatic logic [7:0] bcd_k(input logic [7:0] sum1,
                                        input logic       hc1,
                                        input logic       acr1);
      logic [7:0] k;
      k = 8'h00;
      if (hc1)                 k = k + BCD_LO_ADJ;
      if (acr1)                k = k + BCD_HI_ADJ;
      if (sum1[3:0] >= 4'hA)   k = k + BCD_NIB_FIX;
      return k;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response channel between the instruction decoder
// (master) and the ALU sequencer (slave).
//   req_valid/req_ready        - request handshake
//   req_op/a/b/c/d             - opcode, operands, carry and decimal flags
//   rsp_valid/rsp_ready        - response handshake
//   rsp_result, rsp_n/z/c/v    - result byte and flags
//   rsp_flag_we                - flag write mask {N,Z,C,V}
interface alu_seq_if;

   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_op;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic       req_c;
   logic       req_d;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_result;
   logic       rsp_n;
   logic       rsp_z;
   logic       rsp_c;
   logic       rsp_v;
   logic [3:0] rsp_flag_we;

   modport master (
      output req_valid, req_op, req_a, req_b, req_c, req_d, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v,
             rsp_flag_we
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_c, req_d, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v,
             rsp_flag_we
   );

endinterface

// File: rtl/alu.sv
// alu: 8-bit combinational 6502 datapath.
//   a, b      - operands
//   addc      - carry in (also the bit shifted into bit 7 on srs)
//   sums/ands/ors/eors/srs - function select, first asserted wins
//   daa       - decimal carry detection on sums (nibble carries at >9)
//   result    - output byte
//   hc        - carry out of the low nibble
//   acr       - carry out (bit 0 shifted out on srs)
//   avr       - signed overflow on sums
module alu (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       addc,
   input  logic       sums,
   input  logic       ands,
   input  logic       ors,
   input  logic       eors,
   input  logic       srs,
   input  logic       daa,
   output logic [7:0] result,
   output logic       hc,
   output logic       acr,
   output logic       avr
);

   logic [4:0] lo_sum;
   logic [4:0] hi_sum;
   logic       lo_carry;

   always_comb begin
      lo_sum   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, addc};
      lo_carry = daa ? (lo_sum > 5'd9) : lo_sum[4];
      hi_sum   = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, lo_carry};
   end

   always_comb begin
      result = 8'h00;
      hc     = 1'b0;
      acr    = 1'b0;
      avr    = 1'b0;
      if (sums) begin
         result = {hi_sum[3:0], lo_sum[3:0]};
         hc     = lo_carry;
         acr    = daa ? (hi_sum > 5'd9) : hi_sum[4];
         avr    = (a[7] == b[7]) && (hi_sum[3] != a[7]);
      end else if (ands) begin
         result = a & b;
      end else if (ors) begin
         result = a | b;
      end else if (eors) begin
         result = a ^ b;
      end else if (srs) begin
         result = {addc, a[7:1]};
         acr    = a[0];
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one 6502 ALU operation per request through a
// single alu instance and returns result + flags on a response channel.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - alu_seq_if slave: request in, response out
// Build option: define ALU_SEQ_DECIMAL_EN to include the BCD adjust pass
// for ADC with D=1. Without it ADC is always binary and req_d is ignored.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// EXEC  | main ALU pass on the latched operands
// ADJ   | decimal ADC correction pass (sum1 + K)
// DONE  | response valid, waiting for rsp_ready
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);

   state_e     state_q, state_d;
   logic [7:0] a_q, b_q;
   logic       c_q;
   logic [3:0] op_q;

   logic [7:0] alu_a, alu_b, alu_result;
   logic       alu_addc, alu_sums, alu_ands, alu_ors, alu_eors, alu_srs, alu_daa;
   logic       alu_hc, alu_acr, alu_avr;

   logic [3:0] flag_we;
   logic       pass_a;
   logic       is_dec;
   logic       accept;
   logic       load_rsp;
   logic [7:0] res_d;
   logic [3:0] nzcv_d;

   logic [7:0] rsp_result_q;
   logic [3:0] rsp_nzcv_q;
   logic [3:0] rsp_we_q;

`ifdef ALU_SEQ_DECIMAL_EN
   logic       d_q;
   logic [7:0] sum1_q;
   logic       hc1_q, acr1_q, avr1_q;

   assign is_dec = (op_q == OP_ADC) && d_q;
`else
   logic unused_ok;

   assign is_dec    = 1'b0;
   assign unused_ok = ^{bus.req_d, alu_hc};
`endif

   assign accept   = bus.req_valid && (state_q == IDLE);
   assign load_rsp = ((state_q == EXEC) && !is_dec) || (state_q == ADJ);

   always_comb begin
      alu_a    = a_q;
      alu_b    = b_q;
      alu_addc = c_q;
      alu_sums = 1'b0;
      alu_ands = 1'b0;
      alu_ors  = 1'b0;
      alu_eors = 1'b0;
      alu_srs  = 1'b0;
      alu_daa  = 1'b0;
      flag_we  = FLAGS_NONE;
      pass_a   = 1'b0;
      case (op_q)
         OP_ADC: begin
            alu_sums = 1'b1;
            flag_we  = FLAGS_NZCV;
`ifdef ALU_SEQ_DECIMAL_EN
            alu_daa  = d_q && (state_q == EXEC);
`endif
         end
         OP_SBC: begin
            alu_b    = ~b_q;
            alu_sums = 1'b1;
            flag_we  = FLAGS_NZCV;
         end
         // N/Z come from the difference; the accumulator is returned as-is.
         OP_CMP: begin
            alu_b    = ~b_q;
            alu_addc = 1'b1;
            alu_sums = 1'b1;
            flag_we  = FLAGS_NZC;
            pass_a   = 1'b1;
         end
         OP_AND: begin
            alu_ands = 1'b1;
            flag_we  = FLAGS_NZ;
         end
         OP_ORA: begin
            alu_ors  = 1'b1;
            flag_we  = FLAGS_NZ;
         end
         OP_EOR: begin
            alu_eors = 1'b1;
            flag_we  = FLAGS_NZ;
         end
         OP_LSR: begin
            alu_srs  = 1'b1;
            alu_addc = 1'b0;
            flag_we  = FLAGS_NZC;
         end
         OP_ROR: begin
            alu_srs  = 1'b1;
            flag_we  = FLAGS_NZC;
         end
         OP_ASL: begin
            alu_b    = a_q;
            alu_addc = 1'b0;
            alu_sums = 1'b1;
            flag_we  = FLAGS_NZC;
         end
         OP_ROL: begin
            alu_b    = a_q;
            alu_sums = 1'b1;
            flag_we  = FLAGS_NZC;
         end
         default: pass_a = 1'b1;
      endcase
`ifdef ALU_SEQ_DECIMAL_EN
      if (state_q == ADJ) begin
         alu_a    = sum1_q;
         alu_b    = bcd_k(sum1_q, hc1_q, acr1_q);
         alu_addc = 1'b0;
         alu_sums = 1'b1;
         alu_ands = 1'b0;
         alu_ors  = 1'b0;
         alu_eors = 1'b0;
         alu_srs  = 1'b0;
         alu_daa  = 1'b0;
         flag_we  = FLAGS_NZCV;
         pass_a   = 1'b0;
      end
`endif
   end

   // Flags outside the mask read 0; on the adjust pass C/V come from pass 1.
   always_comb begin
      res_d     = pass_a ? a_q : alu_result;
      nzcv_d    = {alu_result[7], (alu_result == 8'h00), alu_acr, alu_avr} & flag_we;
`ifdef ALU_SEQ_DECIMAL_EN
      if (state_q == ADJ) begin
         nzcv_d = {alu_result[7], (alu_result == 8'h00), acr1_q, avr1_q};
      end
`endif
   end

   alu u_alu (
      .a      (alu_a),
      .b      (alu_b),
      .addc   (alu_addc),
      .sums   (alu_sums),
      .ands   (alu_ands),
      .ors    (alu_ors),
      .eors   (alu_eors),
      .srs    (alu_srs),
      .daa    (alu_daa),
      .result (alu_result),
      .hc     (alu_hc),
      .acr    (alu_acr),
      .avr    (alu_avr)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req_valid) state_d = EXEC;
         EXEC:    state_d = is_dec ? ADJ : DONE;
         ADJ:     state_d = DONE;
         DONE:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= 8'h00;
         b_q          <= 8'h00;
         c_q          <= 1'b0;
         op_q         <= 4'h0;
         rsp_result_q <= 8'h00;
         rsp_nzcv_q   <= 4'b0000;
         rsp_we_q     <= 4'b0000;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q  <= bus.req_a;
            b_q  <= bus.req_b;
            c_q  <= bus.req_c;
            op_q <= bus.req_op;
         end
         if (load_rsp) begin
            rsp_result_q <= res_d;
            rsp_nzcv_q   <= nzcv_d;
            rsp_we_q     <= flag_we;
         end
      end
   end

`ifdef ALU_SEQ_DECIMAL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q    <= 1'b0;
         sum1_q <= 8'h00;
         hc1_q  <= 1'b0;
         acr1_q <= 1'b0;
         avr1_q <= 1'b0;
      end else begin
         if (accept) d_q <= bus.req_d;
         if ((state_q == EXEC) && is_dec) begin
            sum1_q <= alu_result;
            hc1_q  <= alu_hc;
            acr1_q <= alu_acr;
            avr1_q <= alu_avr;
         end
      end
   end
`endif

   assign bus.req_ready   = (state_q == IDLE);
   assign bus.rsp_valid   = (state_q == DONE);
   assign bus.rsp_result  = rsp_result_q;
   assign bus.rsp_n       = rsp_nzcv_q[3];
   assign bus.rsp_z       = rsp_nzcv_q[2];
   assign bus.rsp_c       = rsp_nzcv_q[1];
   assign bus.rsp_v       = rsp_nzcv_q[0];
   assign bus.rsp_flag_we = rsp_we_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
   import alu_seq_pkg::*;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic       d;
      logic [7:0] res;
      logic [3:0] nzcv;
      logic [3:0] we;
      int         lat;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   vec_t vecs[17];

   alu_seq_if bus_if ();

   alu_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic c, input logic d,
                               input logic [7:0] res, input logic [3:0] nzcv,
                               input logic [3:0] we, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.c = c; v.d = d;
      v.res = res; v.nzcv = nzcv; v.we = we; v.lat = lat;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] flags();
      return {bus_if.rsp_n, bus_if.rsp_z, bus_if.rsp_c, bus_if.rsp_v};
   endfunction

   task automatic send(input vec_t v);
      bus_if.req_op    = v.op;
      bus_if.req_a     = v.a;
      bus_if.req_b     = v.b;
      bus_if.req_c     = v.c;
      bus_if.req_d     = v.d;
      bus_if.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!bus_if.rsp_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic apply(input string tag, input vec_t v);
      int lat;
      check({tag, " req_ready"}, bus_if.req_ready, 1);
      send(v);
      wait_rsp(lat);
      check({tag, " latency"}, lat, v.lat);
      check({tag, " result"}, bus_if.rsp_result, v.res);
      check({tag, " nzcv"}, flags(), v.nzcv);
      check({tag, " flag_we"}, bus_if.rsp_flag_we, v.we);
      bus_if.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.rsp_ready = 1'b0;
      check({tag, " rsp_valid drop"}, bus_if.rsp_valid, 0);
   endtask

   initial begin
      int lat;
      total = 0;
      bad   = 0;

      vecs[0]  = mk(OP_ADC, 8'h50, 8'h50, 0, 0, 8'hA0, 4'b1001, 4'b1111, 1);
`ifdef ALU_SEQ_DECIMAL_EN
      vecs[1]  = mk(OP_ADC, 8'h99, 8'h01, 0, 1, 8'h00, 4'b0110, 4'b1111, 2);
      vecs[2]  = mk(OP_ADC, 8'h58, 8'h46, 0, 1, 8'h04, 4'b0011, 4'b1111, 2);
      vecs[16] = mk(OP_ADC, 8'h09, 8'h01, 0, 1, 8'h10, 4'b0000, 4'b1111, 2);
`else
      vecs[1]  = mk(OP_ADC, 8'h99, 8'h01, 0, 1, 8'h9A, 4'b1000, 4'b1111, 1);
      vecs[2]  = mk(OP_ADC, 8'h58, 8'h46, 0, 1, 8'h9E, 4'b1001, 4'b1111, 1);
      vecs[16] = mk(OP_ADC, 8'h09, 8'h01, 0, 1, 8'h0A, 4'b0000, 4'b1111, 1);
`endif
      vecs[3]  = mk(OP_SBC, 8'h50, 8'hB0, 1, 0, 8'hA0, 4'b1001, 4'b1111, 1);
      vecs[4]  = mk(OP_CMP, 8'h40, 8'h40, 0, 0, 8'h40, 4'b0110, 4'b1110, 1);
      vecs[5]  = mk(OP_ROR, 8'h01, 8'h00, 1, 0, 8'h80, 4'b1010, 4'b1110, 1);
      vecs[6]  = mk(OP_LSR, 8'h01, 8'h00, 0, 0, 8'h00, 4'b0110, 4'b1110, 1);
      vecs[7]  = mk(OP_ROL, 8'h80, 8'h00, 1, 0, 8'h01, 4'b0010, 4'b1110, 1);
      vecs[8]  = mk(4'hC,   8'h37, 8'h12, 1, 1, 8'h37, 4'b0000, 4'b0000, 1);
      vecs[9]  = mk(OP_AND, 8'hF0, 8'h3C, 0, 0, 8'h30, 4'b0000, 4'b1100, 1);
      vecs[10] = mk(OP_ORA, 8'h80, 8'h01, 0, 0, 8'h81, 4'b1000, 4'b1100, 1);
      vecs[11] = mk(OP_EOR, 8'h5A, 8'h5A, 0, 0, 8'h00, 4'b0100, 4'b1100, 1);
      vecs[12] = mk(OP_ASL, 8'hC1, 8'h00, 1, 0, 8'h82, 4'b1010, 4'b1110, 1);
      vecs[13] = mk(OP_SBC, 8'h10, 8'h01, 1, 1, 8'h0F, 4'b0010, 4'b1111, 1);
      vecs[14] = mk(OP_CMP, 8'h10, 8'h20, 0, 0, 8'h10, 4'b1000, 4'b1110, 1);
      vecs[15] = mk(OP_ADC, 8'hFF, 8'h00, 1, 0, 8'h00, 4'b0110, 4'b1111, 1);

      rst_n            = 1'b0;
      bus_if.req_valid = 1'b0;
      bus_if.req_op    = 4'h0;
      bus_if.req_a     = 8'h00;
      bus_if.req_b     = 8'h00;
      bus_if.req_c     = 1'b0;
      bus_if.req_d     = 1'b0;
      bus_if.rsp_ready = 1'b0;
      #12;
      check("reset rsp_valid", bus_if.rsp_valid, 0);
      check("reset result", bus_if.rsp_result, 8'h00);
      check("reset nzcv", flags(), 4'b0000);
      check("reset flag_we", bus_if.rsp_flag_we, 4'b0000);
      check("reset req_ready", bus_if.req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         apply($sformatf("vec%0d", i), vecs[i]);
      end

      // Back-pressure: response must hold while a new request waits.
      send(vecs[0]);
      wait_rsp(lat);
      check("hold latency", lat, 1);
      bus_if.req_op    = OP_AND;
      bus_if.req_a     = 8'hF0;
      bus_if.req_b     = 8'h3C;
      bus_if.req_c     = 1'b0;
      bus_if.req_d     = 1'b0;
      bus_if.req_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold%0d result", k), bus_if.rsp_result, 8'hA0);
         check($sformatf("hold%0d rsp_valid", k), bus_if.rsp_valid, 1);
         check($sformatf("hold%0d req_ready", k), bus_if.req_ready, 0);
      end
      bus_if.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.rsp_ready = 1'b0;
      check("release req_ready", bus_if.req_ready, 1);
      check("release rsp_valid", bus_if.rsp_valid, 0);
      @(posedge clk);
      #1;
      bus_if.req_valid = 1'b0;
      check("queued accept req_ready", bus_if.req_ready, 0);
      wait_rsp(lat);
      check("queued latency", lat, 1);
      check("queued result", bus_if.rsp_result, 8'h30);
      check("queued flag_we", bus_if.rsp_flag_we, 4'b1100);
      bus_if.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_if.rsp_ready = 1'b0;

      // Reset with an operation in flight (in ADJ when decimal is built in).
      send(vecs[1]);
`ifdef ALU_SEQ_DECIMAL_EN
      @(posedge clk);
      #1;
`endif
      rst_n = 1'b0;
      #1;
      check("midreset rsp_valid", bus_if.rsp_valid, 0);
      check("midreset result", bus_if.rsp_result, 8'h00);
      check("midreset nzcv", flags(), 4'b0000);
      check("midreset flag_we", bus_if.rsp_flag_we, 4'b0000);
      check("midreset req_ready", bus_if.req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("postreset%0d rsp_valid", k), bus_if.rsp_valid, 0);
      end
      apply("postreset vec2", vecs[2]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
